// File: rtl/hexchar_stream.sv
// Streams the hex characters of a latched value over a valid/ready char interface,
// most significant digit first, with optional "0x" prefix, zero suppression and terminator.
module hexchar_stream #(
    parameter int unsigned          NUM_DIGITS = 8,
    parameter int unsigned          DIGIT_SIZE = 4,
    parameter int unsigned          CHAR_SIZE  = 8,
    parameter bit                   UPPERCASE  = 1'b0,
    parameter bit                   PREFIX     = 1'b1,
    parameter logic [CHAR_SIZE-1:0] TERM_CHAR  = '0
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_start,
    input  logic [DIGIT_SIZE*NUM_DIGITS-1:0] in_value,
    input  logic                             in_skip_zeros,
    output logic                             out_busy,
    output logic [CHAR_SIZE-1:0]             out_char,
    output logic                             out_char_valid,
    input  logic                             in_char_ready,
    output logic                             out_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = DIGIT_SIZE * NUM_DIGITS;

    if (DIGIT_SIZE != 4) begin : g_bad_digit_size
        $error("hexchar_stream: DIGIT_SIZE must be 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGITS,
        S_TERM,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [VAL_W-1:0]       value_q, value_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   skip_q, skip_d;
    logic                   seen_q, seen_d;
    logic [CHAR_SIZE-1:0]   char_q, char_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   xfer;

    assign xfer = valid_q && in_char_ready;

    function automatic logic [DIGIT_SIZE-1:0] digit_at(input logic [VAL_W-1:0] v,
                                                      input logic [IDX_W-1:0] idx);
        logic [DIGIT_SIZE-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) d = v[i*DIGIT_SIZE +: DIGIT_SIZE];
        end
        return d;
    endfunction

    function automatic logic [CHAR_SIZE-1:0] hex_char(input logic [DIGIT_SIZE-1:0] d);
        logic [7:0] c;
        if (d < DIGIT_SIZE'(10)) c = 8'h30 + 8'(d);
        else                     c = (UPPERCASE ? 8'h37 : 8'h57) + 8'(d);
        return CHAR_SIZE'(c);
    endfunction

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            value_q <= '0;
            idx_q   <= '0;
            skip_q  <= 1'b0;
            seen_q  <= 1'b0;
            char_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            seen_q  <= seen_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // In DIGITS, valid_q low can only mean a suppressed leading zero.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        seen_d  = seen_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    value_d = in_value;
                    skip_d  = in_skip_zeros;
                    seen_d  = 1'b0;
                    idx_d   = IDX_W'(NUM_DIGITS - 1);
                    state_d = PREFIX ? S_PFX0 : S_DIGITS;
                end
            end
            S_PFX0: if (xfer) state_d = S_PFX1;
            S_PFX1: if (xfer) state_d = S_DIGITS;
            S_DIGITS: begin
                if (!valid_q) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (xfer) begin
                    seen_d = 1'b1;
                    if (idx_q == '0) state_d = (TERM_CHAR != '0) ? S_TERM : S_DONE;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            S_TERM:  if (xfer) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered by deriving them from the next-state values.
    always_comb begin
        valid_d = 1'b0;
        char_d  = '0;
        case (state_d)
            S_PFX0: begin
                valid_d = 1'b1;
                char_d  = CHAR_SIZE'(8'h30);
            end
            S_PFX1: begin
                valid_d = 1'b1;
                char_d  = CHAR_SIZE'(8'h78);
            end
            S_DIGITS: begin
                if (!(skip_d && !seen_d && (idx_d != '0) && (digit_at(value_d, idx_d) == '0))) begin
                    valid_d = 1'b1;
                    char_d  = hex_char(digit_at(value_d, idx_d));
                end
            end
            S_TERM: begin
                valid_d = 1'b1;
                char_d  = TERM_CHAR;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign out_busy       = busy_q;
    assign out_char       = char_q;
    assign out_char_valid = valid_q;
    assign out_done       = done_q;

endmodule

// File: tb/tb_hexchar_stream.sv
// Bench for hexchar_stream: three configurations share stimulus, each stream is
// checked against a token list built from the value, skip flag and configuration.
module tb_hexchar_stream;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             skip = 1'b0;
    logic             ready = 1'b0;
    logic [W-1:0]     value = '0;
    logic [2:0]       busy, valid, done;
    logic [2:0][7:0]  ch;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_c[$];
    bit         exp_v[$];

    always #5 clk = ~clk;

    hexchar_stream #(.NUM_DIGITS(N), .DIGIT_SIZE(4), .CHAR_SIZE(8), .UPPERCASE(1'b0),
                     .PREFIX(1'b1), .TERM_CHAR(8'h00)) u_lower (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_value(value),
        .in_skip_zeros(skip), .out_busy(busy[0]), .out_char(ch[0]),
        .out_char_valid(valid[0]), .in_char_ready(ready), .out_done(done[0]));

    hexchar_stream #(.NUM_DIGITS(N), .DIGIT_SIZE(4), .CHAR_SIZE(8), .UPPERCASE(1'b0),
                     .PREFIX(1'b1), .TERM_CHAR(8'h0a)) u_term (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_value(value),
        .in_skip_zeros(skip), .out_busy(busy[1]), .out_char(ch[1]),
        .out_char_valid(valid[1]), .in_char_ready(ready), .out_done(done[1]));

    hexchar_stream #(.NUM_DIGITS(N), .DIGIT_SIZE(4), .CHAR_SIZE(8), .UPPERCASE(1'b1),
                     .PREFIX(1'b0), .TERM_CHAR(8'h00)) u_upper (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_value(value),
        .in_skip_zeros(skip), .out_busy(busy[2]), .out_char(ch[2]),
        .out_char_valid(valid[2]), .in_char_ready(ready), .out_done(done[2]));

    function automatic bit cfg_prefix(input int inst);
        return inst != 2;
    endfunction

    function automatic bit cfg_upper(input int inst);
        return inst == 2;
    endfunction

    function automatic logic [7:0] cfg_term(input int inst);
        return (inst == 1) ? 8'h0a : 8'h00;
    endfunction

    function automatic logic pick_ready(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Expected output tokens: a char token waits for ready, a skip token lasts one cycle.
    task automatic build_model(input int inst, input logic [W-1:0] v, input logic sk);
        string       hx;
        bit          started;
        int unsigned nib;
        hx = cfg_upper(inst) ? "0123456789ABCDEF" : "0123456789abcdef";
        exp_c.delete();
        exp_v.delete();
        if (cfg_prefix(inst)) begin
            exp_v.push_back(1'b1); exp_c.push_back("0");
            exp_v.push_back(1'b1); exp_c.push_back("x");
        end
        started = 1'b0;
        for (int d = N - 1; d >= 0; d--) begin
            nib = (int'(v) >> (4 * d)) % 16;
            if (sk && !started && nib == 0 && d != 0) begin
                exp_v.push_back(1'b0); exp_c.push_back(8'h00);
            end else begin
                started = 1'b1;
                exp_v.push_back(1'b1); exp_c.push_back(hx[nib]);
            end
        end
        if (cfg_term(inst) != 8'h00) begin
            exp_v.push_back(1'b1); exp_c.push_back(cfg_term(inst));
        end
    endtask

    // Called at a negedge with the target instance idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic stream(input int inst, input logic [W-1:0] v, input logic sk, input int rmode,
                          input bit inject, input bit b2b, input logic [W-1:0] nv);
        int         pos, cyc;
        bit         hold;
        logic [7:0] held;
        build_model(inst, v, sk);
        value = v;
        skip  = sk;
        start = 1'b1;
        @(negedge clk);
        pos = 0; cyc = 0; hold = 1'b0; held = '0;
        while (pos < exp_v.size() && cyc < 200) begin
            start = inject && (cyc == 3);
            value = start ? 16'h1234 : W'($urandom);
            skip  = 1'($urandom);
            ready = pick_ready(rmode, cyc);
            checks++;
            if (busy[inst] !== 1'b1 || done[inst] !== 1'b0) begin
                errors++;
                $display("FAIL busy_done inst=%0d cyc=%0d got busy=%b done=%b exp busy=1 done=0", inst, cyc, busy[inst], done[inst]);
            end
            checks++;
            if (valid[inst] !== exp_v[pos]) begin
                errors++;
                $display("FAIL valid inst=%0d tok=%0d got %b exp %b", inst, pos, valid[inst], exp_v[pos]);
            end
            if (exp_v[pos]) begin
                checks++;
                if (ch[inst] !== exp_c[pos]) begin
                    errors++;
                    $display("FAIL char inst=%0d tok=%0d got %h exp %h", inst, pos, ch[inst], exp_c[pos]);
                end
            end
            if (hold) begin
                checks++;
                if (ch[inst] !== held || valid[inst] !== 1'b1) begin
                    errors++;
                    $display("FAIL hold inst=%0d tok=%0d got %h/%b exp %h/1", inst, pos, ch[inst], valid[inst], held);
                end
            end
            if (exp_v[pos]) begin
                hold = !ready;
                held = ch[inst];
                if (ready) pos++;
            end else begin
                hold = 1'b0;
                pos++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pos != exp_v.size()) begin
            errors++;
            $display("FAIL stream_timeout inst=%0d got %0d tokens exp %0d", inst, pos, exp_v.size());
        end
        checks++;
        if (done[inst] !== 1'b1 || busy[inst] !== 1'b1 || valid[inst] !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle inst=%0d got done=%b busy=%b valid=%b exp 1 1 0", inst, done[inst], busy[inst], valid[inst]);
        end
        if (b2b) begin
            start = 1'b1;
            value = nv;
        end
        @(negedge clk);
        checks++;
        if (busy[inst] !== 1'b0 || done[inst] !== 1'b0 || valid[inst] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after inst=%0d got busy=%b done=%b valid=%b exp 0 0 0", inst, busy[inst], done[inst], valid[inst]);
        end
    endtask

    task automatic wait_all_idle();
        int n;
        n = 0;
        start = 1'b0;
        while (busy !== 3'b000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b exp 000", busy);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 3'b000 || valid !== 3'b000 || done !== 3'b000 || ch !== '0) begin
            errors++;
            $display("FAIL reset_async got busy=%b valid=%b done=%b ch=%h exp all 0", busy, valid, done, ch);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 3'b000 || valid !== 3'b000 || done !== 3'b000 || ch !== '0) begin
            errors++;
            $display("FAIL reset_hold got busy=%b valid=%b done=%b ch=%h exp all 0", busy, valid, done, ch);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wait_all_idle();
        stream(0, 16'h0a3f, 1'b0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_skip_zeros();
        wait_all_idle();
        stream(0, 16'h0a3f, 1'b1, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_zero_term();
        wait_all_idle();
        stream(1, 16'h0000, 1'b1, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        wait_all_idle();
        stream(2, 16'hbeef, 1'b0, 1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        wait_all_idle();
        stream(0, 16'hc0de, 1'b0, 0, 1'b1, 1'b1, 16'h1234);
        stream(0, 16'h1234, 1'b0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_mid_reset();
        wait_all_idle();
        value = 16'h0a3f;
        skip  = 1'b0;
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (valid[0] !== 1'b1 || ch[0] !== 8'h78) begin
            errors++;
            $display("FAIL pre_reset got valid=%b ch=%h exp 1 78", valid[0], ch[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 3'b000 || valid !== 3'b000 || done !== 3'b000 || ch !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b valid=%b done=%b ch=%h exp all 0", busy, valid, done, ch);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 3'b000 || busy !== 3'b000) begin
                errors++;
                $display("FAIL post_reset got done=%b busy=%b exp 000 000", done, busy);
            end
        end
        stream(0, 16'h0a3f, 1'b0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [W-1:0] mask, v;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0:       mask = 16'hffff;
                1:       mask = 16'h0fff;
                2:       mask = 16'h00ff;
                3:       mask = 16'h000f;
                default: mask = 16'h0000;
            endcase
            v = W'($urandom) & mask;
            wait_all_idle();
            stream($urandom_range(0, 2), v, 1'($urandom), 2, 1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_skip_zeros();
        test_zero_term();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        wait_all_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
